// File: rtl/periph_rx_arbiter.sv
// rtl/periph_rx_arbiter.sv - round-robin drain of peripheral RX FIFOs into the USB TX FIFO
module periph_rx_arbiter #(
    parameter int NUM_PERIPHS = 8,
    parameter int PKT_W       = 32,
    parameter int ADDR_W      = 3,
    parameter int MAX_BURST   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PERIPHS-1:0][PKT_W-ADDR_W-1:0] periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]                 periph_rx_empty,
    output logic [NUM_PERIPHS-1:0]                 periph_rx_rden,
    input  logic [NUM_PERIPHS-1:0]                 periph_enable,
    output logic [PKT_W-1:0]                       usb_tx_data,
    output logic                                   usb_tx_wren,
    input  logic                                   usb_tx_full,
    output logic [ADDR_W-1:0]                      grant_id,
    output logic                                   busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   grant_q, grant_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;

    logic [NUM_PERIPHS-1:0] req;
    logic                   found;
    logic [ADDR_W-1:0]      pick;
    logic                   pop;
    logic [ADDR_W-1:0]      next_ptr;
    logic [NUM_PERIPHS-1:0] rden_c;
    logic [PKT_W-1:0]       data_c;

    assign req      = ~periph_rx_empty & periph_enable;
    assign pop      = (state_q == XFER) & req[grant_q] & ~usb_tx_full;
    assign next_ptr = (int'(grant_q) + 1 == NUM_PERIPHS) ? '0 : grant_q + ADDR_W'(1);

    // First requesting slot at or after rr_ptr, wrapping modulo NUM_PERIPHS
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = rr_ptr_q;
        for (int k = 0; k < NUM_PERIPHS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PERIPHS) idx = idx - NUM_PERIPHS;
            if (!found && req[ADDR_W'(idx)]) begin
                found = 1'b1;
                pick  = ADDR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        rden_c      = '0;
        data_c      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (pop) begin
                    rden_c[grant_q] = 1'b1;
                    data_c          = {grant_q, periph_rx_data[grant_q]};
                    burst_cnt_d     = burst_cnt_q + 4'd1;
                end
                if ((pop && burst_cnt_q == 4'(MAX_BURST - 1)) || !req[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Outputs are forced low during reset so a pop in the reset cycle is dropped
    assign periph_rx_rden = rst ? '0 : rden_c;
    assign usb_tx_wren    = ~rst & pop;
    assign usb_tx_data    = rst ? '0 : data_c;
    assign grant_id       = rst ? '0 : grant_q;
    assign busy           = ~rst & (state_q == XFER);

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// tb/tb_periph_rx_arbiter.sv - scoreboard bench for periph_rx_arbiter
module tb_periph_rx_arbiter;
    localparam int N  = 8;
    localparam int DW = 29;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0][DW-1:0] rx_data = '0;
    logic [N-1:0]         rx_empty = '1;
    logic [N-1:0]         rden;
    logic [N-1:0]         en = '0;
    logic [31:0]          tx_data;
    logic                 wren;
    logic                 full = 1'b0;
    logic [2:0]           gid;
    logic                 busy;

    logic [DW-1:0] fifo [N][$];
    logic [31:0]   exp_q[$];
    int            wr_cyc[$];
    int            cyc = 0;
    int            wr_cnt = 0;
    int            errors = 0;
    int            checks = 0;

    periph_rx_arbiter dut (
        .clk(clk), .rst(rst),
        .periph_rx_data(rx_data), .periph_rx_empty(rx_empty), .periph_rx_rden(rden),
        .periph_enable(en), .usb_tx_data(tx_data), .usb_tx_wren(wren),
        .usb_tx_full(full), .grant_id(gid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // FIFO model and write monitor: sample at negedge, pop after the next posedge
    initial begin
        logic [N-1:0] s_rden;
        logic [31:0]  e;
        forever begin
            @(negedge clk);
            cyc++;
            s_rden = rden;
            if (wren) begin
                wr_cnt++;
                wr_cyc.push_back(cyc);
                check_eq("wr_while_full", 32'(full), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("tx_data", tx_data, e);
                end
            end
            if (wren || rden != '0)
                check_eq("rden_onehot", 32'(rden), wren ? 32'(8'd1 << tx_data[31:29]) : 32'd0);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (s_rden[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
                rx_empty[i] = (fifo[i].size() == 0);
                rx_data[i]  = (fifo[i].size() != 0) ? fifo[i][0] : '0;
            end
        end
    end

    task automatic push(input int s, input logic [DW-1:0] w, input bit expect_it);
        fifo[s].push_back(w);
        if (expect_it) exp_q.push_back({3'(s), w});
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int n = 0;
        while (wr_cnt < target && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq(tag, 32'(wr_cnt >= target), 32'd1);
    endtask

    initial begin
        int base;
        int offs[6];
        offs = '{0, 1, 2, 3, 5, 6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wren", 32'(wren), 32'd0);
        check_eq("rst_rden", 32'(rden), 32'd0);
        check_eq("rst_data", tx_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gid", 32'(gid), 32'd0);
        check_eq("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        en  = '1;

        // single requester, slot 2
        base = wr_cyc.size();
        for (int w = 1; w <= 3; w++) push(2, DW'(w), 1'b0);
        exp_q.push_back(32'h40000001);
        exp_q.push_back(32'h40000002);
        exp_q.push_back(32'h40000003);
        wait_drain("t1_drain");
        check_eq("t1_back_to_back", 32'(wr_cyc[base+2] - wr_cyc[base]), 32'd2);
        check_eq("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

        // burst limit, slot 0 with 6 words
        base = wr_cyc.size();
        for (int w = 0; w < 6; w++) push(0, DW'(32'h100 + w), 1'b1);
        wait_drain("t2_drain");
        for (int k = 0; k < 6; k++)
            check_eq("t2_spacing", 32'(wr_cyc[base+k] - wr_cyc[base]), 32'(offs[k]));

        // round robin with wrap from rr_ptr 6
        push(5, DW'(32'h55), 1'b1);
        wait_drain("t3_pre_drain");
        check_eq("t3_rr_ptr", 32'(dut.rr_ptr_q), 32'd6);
        fifo[1].push_back(DW'(32'h0B));
        fifo[5].push_back(DW'(32'h0C));
        fifo[7].push_back(DW'(32'h0A));
        exp_q.push_back({3'b111, DW'(32'h0A)});
        exp_q.push_back({3'b001, DW'(32'h0B)});
        exp_q.push_back({3'b101, DW'(32'h0C)});
        wait_drain("t3_drain");

        // backpressure mid-burst
        base = wr_cnt;
        for (int w = 1; w <= 4; w++) push(4, DW'(32'h40 + w), 1'b1);
        wait_wr(base + 2, "t4_start");
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t4_bp_wren", 32'(wren), 32'd0);
            check_eq("t4_bp_rden", 32'(rden), 32'd0);
            check_eq("t4_bp_busy", 32'(busy), 32'd1);
            @(posedge clk); #2;
        end
        full = 1'b0;
        wait_drain("t4_drain");
        check_eq("t4_count", 32'(wr_cnt - base), 32'd4);

        // enable mask, then disable the granted slot mid-burst
        en[3] = 1'b0;
        base  = wr_cnt;
        push(3, DW'(32'h31), 1'b0);
        push(3, DW'(32'h32), 1'b0);
        repeat (10) @(posedge clk);
        #2;
        check_eq("t5_masked", 32'(wr_cnt - base), 32'd0);
        check_eq("t5_masked_busy", 32'(busy), 32'd0);
        push(6, DW'(32'h61), 1'b1);
        push(6, DW'(32'h62), 1'b1);
        push(6, DW'(32'h63), 1'b0);
        push(6, DW'(32'h64), 1'b0);
        wait_wr(base + 2, "t5_start");
        en[6] = 1'b0;
        @(negedge clk);
        check_eq("t5_dis_wren", 32'(wren), 32'd0);
        check_eq("t5_dis_rden", 32'(rden), 32'd0);
        @(posedge clk); #2;
        check_eq("t5_dis_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        check_eq("t5_dis_count", 32'(wr_cnt - base), 32'd2);
        exp_q.push_back({3'd3, DW'(32'h31)});
        exp_q.push_back({3'd3, DW'(32'h32)});
        exp_q.push_back({3'd6, DW'(32'h63)});
        exp_q.push_back({3'd6, DW'(32'h64)});
        en = '1;
        wait_drain("t5_drain");

        // reset on the second pop of a 4-word burst
        base = wr_cnt;
        for (int w = 1; w <= 4; w++) push(1, DW'(32'h10 + w), 1'b1);
        wait_wr(base + 1, "t6_start");
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_wren", 32'(wren), 32'd0);
        check_eq("t6_rst_rden", 32'(rden), 32'd0);
        check_eq("t6_rst_data", tx_data, 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_gid", 32'(gid), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        check_eq("t6_idle", 32'(busy), 32'd0);
        wait_drain("t6_drain");
        check_eq("t6_count", 32'(wr_cnt - base), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
